// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: opcodes, control-word bit positions,
// and the pre-assembled control words used by the micro sequencer.
package cpu_pkg;

    localparam int TSTATE_W = 3;
    localparam int CTRL_W   = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int FI  = 0;
    localparam int J   = 1;
    localparam int CO  = 2;
    localparam int CE  = 3;
    localparam int OI  = 4;
    localparam int BI  = 5;
    localparam int SU  = 6;
    localparam int SO  = 7;
    localparam int AO  = 8;
    localparam int AI  = 9;
    localparam int II  = 10;
    localparam int IO  = 11;
    localparam int RO  = 12;
    localparam int RI  = 13;
    localparam int MI  = 14;
    localparam int HLT = 15;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    localparam logic [CTRL_W-1:0] CTRL_FETCH0   = cbit(MI) | cbit(CO);
    localparam logic [CTRL_W-1:0] CTRL_FETCH1   = cbit(RO) | cbit(II) | cbit(CE);
    localparam logic [CTRL_W-1:0] CTRL_ADDR     = cbit(MI) | cbit(IO);
    localparam logic [CTRL_W-1:0] CTRL_LOAD_A   = cbit(RO) | cbit(AI);
    localparam logic [CTRL_W-1:0] CTRL_LOAD_B   = cbit(RO) | cbit(BI);
    localparam logic [CTRL_W-1:0] CTRL_SUM_A    = cbit(SO) | cbit(AI) | cbit(FI);
    localparam logic [CTRL_W-1:0] CTRL_DIFF_A   = cbit(SO) | cbit(SU) | cbit(AI) | cbit(FI);
    localparam logic [CTRL_W-1:0] CTRL_STORE_A  = cbit(AO) | cbit(RI);
    localparam logic [CTRL_W-1:0] CTRL_IMM_A    = cbit(IO) | cbit(AI);
    localparam logic [CTRL_W-1:0] CTRL_JUMP     = cbit(IO) | cbit(J);
    localparam logic [CTRL_W-1:0] CTRL_OUT_A    = cbit(AO) | cbit(OI);
    localparam logic [CTRL_W-1:0] CTRL_HALT     = cbit(HLT);

endpackage

// File: rtl/step_decode.sv
// Combinational microcode ROM: maps (tstate, opcode, flags) to the raw control
// word for that step and whether it is the final step of the instruction.
module step_decode
    import cpu_pkg::*;
(
    input  logic [TSTATE_W-1:0] tstate,
    input  logic [3:0]          opcode,
    input  logic [1:0]          flags,
    output logic [CTRL_W-1:0]   ctrl_raw,
    output logic                last_step
);

    logic flag_c;
    logic flag_z;

    assign flag_c = flags[1];
    assign flag_z = flags[0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned and no latch is inferred.
        ctrl_raw  = '0;
        last_step = 1'b0;
        case (tstate)
            3'd0: ctrl_raw = CTRL_FETCH0;
            3'd1: begin
                ctrl_raw = CTRL_FETCH1;
                // NOP and the unused opcodes 0x9-0xD have no execute steps.
                last_step = (opcode == OP_NOP) || (opcode >= 4'h9 && opcode <= 4'hD);
            end
            3'd2: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_raw  = CTRL_ADDR;
                        last_step = 1'b0;
                    end
                    OP_LDI: ctrl_raw = CTRL_IMM_A;
                    OP_JMP: ctrl_raw = CTRL_JUMP;
                    OP_JC:  ctrl_raw = flag_c ? CTRL_JUMP : '0;
                    OP_JZ:  ctrl_raw = flag_z ? CTRL_JUMP : '0;
                    OP_OUT: ctrl_raw = CTRL_OUT_A;
                    OP_HLT: ctrl_raw = CTRL_HALT;
                    default: ctrl_raw = '0;
                endcase
            end
            3'd3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: ctrl_raw = CTRL_LOAD_A;
                    OP_ADD, OP_SUB: begin
                        ctrl_raw  = CTRL_LOAD_B;
                        last_step = 1'b0;
                    end
                    OP_STA: ctrl_raw = CTRL_STORE_A;
                    default: ctrl_raw = '0;
                endcase
            end
            3'd4: begin
                last_step = 1'b1;
                case (opcode)
                    OP_ADD: ctrl_raw = CTRL_SUM_A;
                    OP_SUB: ctrl_raw = CTRL_DIFF_A;
                    default: ctrl_raw = '0;
                endcase
            end
            // Unreachable steps fall back to fetch on the next edge.
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microcoded control sequencer: T-state counter, {C,Z} flag register, halt latch
// and run/halt gating around the step_decode microcode table.
module micro_sequencer
    import cpu_pkg::*;
(
    input  logic                CLK,
    input  logic                rst,
    input  logic                run,
    input  logic [3:0]          opcode,
    input  logic                carry_in,
    input  logic                zero_in,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [TSTATE_W-1:0] tstate,
    output logic [1:0]          flags,
    output logic                halted
);

    logic [CTRL_W-1:0] ctrl_raw;
    logic              last_step;

    step_decode u_step_decode (
        .tstate    (tstate),
        .opcode    (opcode),
        .flags     (flags),
        .ctrl_raw  (ctrl_raw),
        .last_step (last_step)
    );

    always_comb begin
        ctrl = '0;
        if (halted)
            ctrl = CTRL_HALT;
        else if (run)
            ctrl = ctrl_raw;
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (rst) begin
            tstate <= '0;
            flags  <= 2'b00;
            halted <= 1'b0;
        end else if (run && !halted) begin
            if (ctrl_raw[FI])
                flags <= {carry_in, zero_in};
            if (ctrl_raw[HLT]) begin
                halted <= 1'b1;
                tstate <= '0;
            end else if (last_step) begin
                tstate <= '0;
            end else begin
                tstate <= tstate + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a randomized
// run against an instruction-table reference model.
module tb_micro_sequencer;

    typedef logic [15:0] word_q_t[$];

    logic        CLK = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  opcode;
    logic        carry_in;
    logic        zero_in;
    logic [15:0] ctrl;
    logic [2:0]  tstate;
    logic [1:0]  flags;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    micro_sequencer dut (
        .CLK      (CLK),
        .rst      (rst),
        .run      (run),
        .opcode   (opcode),
        .carry_in (carry_in),
        .zero_in  (zero_in),
        .ctrl     (ctrl),
        .tstate   (tstate),
        .flags    (flags),
        .halted   (halted)
    );

    // Inputs change and outputs are sampled 1-2 time units after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Per-instruction control-word list as written in the instruction table.
    function automatic word_q_t instr_steps(input logic [3:0] op, input logic [1:0] f);
        word_q_t s;
        s.push_back(16'h4004);
        s.push_back(16'h1408);
        case (op)
            4'h1: begin s.push_back(16'h4800); s.push_back(16'h1200); end
            4'h2: begin s.push_back(16'h4800); s.push_back(16'h1020); s.push_back(16'h0281); end
            4'h3: begin s.push_back(16'h4800); s.push_back(16'h1020); s.push_back(16'h02C1); end
            4'h4: begin s.push_back(16'h4800); s.push_back(16'h2100); end
            4'h5: s.push_back(16'h0A00);
            4'h6: s.push_back(16'h0802);
            4'h7: s.push_back(f[1] ? 16'h0802 : 16'h0000);
            4'h8: s.push_back(f[0] ? 16'h0802 : 16'h0000);
            4'hE: s.push_back(16'h0110);
            4'hF: s.push_back(16'h8000);
            default: ;
        endcase
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; opcode = 4'h0; carry_in = 1'b0; zero_in = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== 16'h4004 || tstate !== 3'd0 || flags !== 2'b00 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ctrl=%h tstate=%0d flags=%b halted=%b want 4004 0 00 0", ctrl, tstate, flags, halted);
        end
    endtask

    task automatic test_lda();
        logic [15:0] exp_c [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004};
        logic [2:0]  exp_t [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        opcode = 4'h1; run = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (ctrl !== exp_c[i] || tstate !== exp_t[i]) begin
                n_fail++;
                $display("FAIL lda_step%0d: ctrl=%h tstate=%0d want ctrl=%h tstate=%0d", i, ctrl, tstate, exp_c[i], exp_t[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_flags_jz();
        opcode = 4'h3; carry_in = 1'b1; zero_in = 1'b1;
        tick(4);
        n_tests++;
        if (ctrl !== 16'h02C1 || tstate !== 3'd4) begin
            n_fail++;
            $display("FAIL sub_t4: ctrl=%h tstate=%0d want 02c1 4", ctrl, tstate);
        end
        tick();
        n_tests++;
        if (flags !== 2'b11 || tstate !== 3'd0) begin
            n_fail++;
            $display("FAIL sub_flags: flags=%b tstate=%0d want 11 0", flags, tstate);
        end
        opcode = 4'h8;
        tick(2);
        n_tests++;
        if (ctrl !== 16'h0802) begin
            n_fail++;
            $display("FAIL jz_taken: ctrl=%h want 0802", ctrl);
        end
        tick();
        opcode = 4'h2; carry_in = 1'b0; zero_in = 1'b0;
        tick(5);
        n_tests++;
        if (flags !== 2'b00 || tstate !== 3'd0) begin
            n_fail++;
            $display("FAIL add_flags: flags=%b tstate=%0d want 00 0", flags, tstate);
        end
        opcode = 4'h8;
        tick(2);
        n_tests++;
        if (ctrl !== 16'h0000 || tstate !== 3'd2) begin
            n_fail++;
            $display("FAIL jz_not_taken: ctrl=%h tstate=%0d want 0000 2", ctrl, tstate);
        end
        tick();
        n_tests++;
        if (ctrl !== 16'h4004 || tstate !== 3'd0) begin
            n_fail++;
            $display("FAIL jz_length: ctrl=%h tstate=%0d want 4004 0", ctrl, tstate);
        end
    endtask

    task automatic test_pause();
        opcode = 4'h2; carry_in = 1'b1; zero_in = 1'b1;
        tick(3);
        n_tests++;
        if (ctrl !== 16'h1020 || tstate !== 3'd3) begin
            n_fail++;
            $display("FAIL pause_pre: ctrl=%h tstate=%0d want 1020 3", ctrl, tstate);
        end
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            carry_in = ~carry_in;
            #1;
            n_tests++;
            if (ctrl !== 16'h0000 || tstate !== 3'd3 || flags !== 2'b00) begin
                n_fail++;
                $display("FAIL pause_hold%0d: ctrl=%h tstate=%0d flags=%b want 0000 3 00", i, ctrl, tstate, flags);
            end
            tick();
        end
        run = 1'b1; carry_in = 1'b1; zero_in = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== 16'h1020 || tstate !== 3'd3) begin
            n_fail++;
            $display("FAIL pause_resume: ctrl=%h tstate=%0d want 1020 3", ctrl, tstate);
        end
        tick();
        n_tests++;
        if (ctrl !== 16'h0281 || tstate !== 3'd4) begin
            n_fail++;
            $display("FAIL pause_t4: ctrl=%h tstate=%0d want 0281 4", ctrl, tstate);
        end
        tick();
        n_tests++;
        if (flags !== 2'b10 || tstate !== 3'd0) begin
            n_fail++;
            $display("FAIL pause_flags: flags=%b tstate=%0d want 10 0", flags, tstate);
        end
    endtask

    task automatic test_halt();
        opcode = 4'hF;
        tick(2);
        n_tests++;
        if (ctrl !== 16'h8000 || tstate !== 3'd2 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL hlt_t2: ctrl=%h tstate=%0d halted=%b want 8000 2 0", ctrl, tstate, halted);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            run = (i % 3 != 2);
            carry_in = ~carry_in; zero_in = ~zero_in;
            #1;
            n_tests++;
            if (ctrl !== 16'h8000 || tstate !== 3'd0 || flags !== 2'b10 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_hold%0d: ctrl=%h tstate=%0d flags=%b halted=%b want 8000 0 10 1", i, ctrl, tstate, flags, halted);
            end
            tick();
        end
        run = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== 16'h4004 || halted !== 1'b0 || tstate !== 3'd0 || flags !== 2'b00) begin
            n_fail++;
            $display("FAIL halt_reset: ctrl=%h halted=%b tstate=%0d flags=%b want 4004 0 0 00", ctrl, halted, tstate, flags);
        end
    endtask

    task automatic test_abort();
        opcode = 4'h3; carry_in = 1'b1; zero_in = 1'b1;
        tick(5);
        opcode = 4'h1;
        tick(3);
        n_tests++;
        if (ctrl !== 16'h1200 || tstate !== 3'd3 || flags !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_pre: ctrl=%h tstate=%0d flags=%b want 1200 3 11", ctrl, tstate, flags);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== 16'h4004 || tstate !== 3'd0 || flags !== 2'b00 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: ctrl=%h tstate=%0d flags=%b halted=%b want 4004 0 00 0", ctrl, tstate, flags, halted);
        end
    endtask

    task automatic test_random();
        int          m_pos = 0;
        logic [1:0]  m_flags = 2'b00;
        logic        m_halted = 1'b0;
        word_q_t     s;
        logic [15:0] exp_ctrl;
        logic [15:0] w;
        int          r;
        rst = 1'b1; run = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (m_pos == 0) begin
                r = int'($urandom_range(0, 31));
                opcode = (r == 0) ? 4'hF : 4'(r % 15);
            end
            run      = ($urandom_range(0, 3) != 0);
            carry_in = 1'($urandom_range(0, 1));
            zero_in  = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 79) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            #1;
            s = instr_steps(opcode, m_flags);
            exp_ctrl = m_halted ? 16'h8000 : (run ? s[m_pos] : 16'h0000);
            n_tests++;
            if (ctrl !== exp_ctrl || tstate !== 3'(m_pos) || flags !== m_flags || halted !== m_halted) begin
                n_fail++;
                $display("FAIL random_cyc%0d: op=%h ctrl=%h tstate=%0d flags=%b halted=%b want %h %0d %b %b",
                         cyc, opcode, ctrl, tstate, flags, halted, exp_ctrl, m_pos, m_flags, m_halted);
            end
            if (rst) begin
                m_pos = 0; m_flags = 2'b00; m_halted = 1'b0;
            end else if (run && !m_halted) begin
                w = s[m_pos];
                if (w[0]) m_flags = {carry_in, zero_in};
                if (w[15]) begin
                    m_halted = 1'b1; m_pos = 0;
                end else if (m_pos == s.size() - 1) begin
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lda();
        test_flags_jz();
        test_pause();
        test_halt();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
